tilemap_ram_arbiter: RTL and testbench
======================================

# tilemap_ram_arbiter

Arbiter for the single-port tilemap index RAM (one byte per cell, 1-cycle registered read latency), shared by three requesters. The requesters are the video lookup pipeline (read-only, latency-critical), the tilemap control engine (scroll/clear read-modify-write traffic) and the CPU port. It issues at most one RAM access per cycle, returns read data to the requester that issued it, and bounds CPU starvation by the control engine.

## Interface
- ADDR_WIDTH, 10: RAM address width; matches the cell index {y[4:0], x[4:0]}.
- DATA_WIDTH, 8: RAM data width.
- STARVE_LIMIT, 4: consecutive cycles the CPU may lose to the control engine before it is forced a grant; legal 1-15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request; never stalled.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_rvalid  out  1  video read data valid.
- ctl_req  in  1  control engine request.
- ctl_we  in  1  control engine write enable (0 = read).
- ctl_addr  in  ADDR_WIDTH  control engine address.
- ctl_wdata  in  DATA_WIDTH  control engine write data.
- ctl_gnt  out  1  control request accepted this cycle (combinational).
- ctl_rvalid  out  1  control read data valid.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- rdata  out  DATA_WIDTH  read data, shared by all requesters; qualify with the *_rvalid strobes.
- ram_addr  out  ADDR_WIDTH  RAM address (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_wdata  out  DATA_WIDTH  RAM write data (registered).
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after the address.

## Operation
- Per-cycle priority:
  - vid_req always wins.
  - Otherwise ctl_req wins, unless starve_cnt == STARVE_LIMIT and cpu_req is high; then the CPU wins.
  - Otherwise cpu_req wins.
- Grants:
  - ctl_gnt and cpu_gnt are high only in the cycle their request wins.
  - The requester holds req/we/addr/wdata stable until it sees its gnt; the transfer is accepted at that clock edge.
  - Video has no gnt; vid_req is accepted on any cycle it is high.
- starve_cnt (4 bits):
  - +1 in each cycle cpu_req is high and ctl wins.
  - Cleared on cpu_gnt, or when cpu_req is low.
  - Unchanged when the video slot wins.
  - Saturates at STARVE_LIMIT.
- Issue: on an accepted transfer, ram_addr/ram_we/ram_wdata load the winner's values at the edge; ram_we = 0 for video. With no winner, ram_we loads 0 and ram_addr/ram_wdata hold.
- Return pipeline:
  - A 2-stage owner tag {none, vid, ctl, cpu} is shifted along with each read.
  - rdata = ram_rdata, passed through combinationally.
  - The matching *_rvalid is driven from stage 2; at most one rvalid is high per cycle.
  - Writes create no rvalid.
- Ordering: accesses reach the RAM in grant order. A read granted after a write to the same address returns the new data.
- Video bandwidth: continuous vid_req starves ctl and CPU indefinitely, by design; the video pipeline only requests 1 cycle in 4, and not during hblank. Starvation protection applies only between ctl and CPU.

## Timing
- Reset values (asynchronous assert):
  - ram_addr = 0, ram_we = 0, ram_wdata = 0.
  - Tag pipeline = none, so all rvalid = 0.
  - starve_cnt = 0.
  - ctl_gnt and cpu_gnt forced 0 while reset is high.
- Reset mid-operation: in-flight reads are dropped (no rvalid after reset); a write already on the RAM port completes only if its edge preceded reset.
- Accept at edge N (grant high in cycle N-1): RAM port shows the access during cycle N; ram_rdata is valid in cycle N+1; *_rvalid and rdata are valid in cycle N+1.
- Read latency: 2 cycles from the gnt cycle to the rvalid cycle, for all requesters.
- Throughput: one access per cycle, with back-to-back grants to any mix of requesters.
- Simultaneous vid+ctl+cpu with starve_cnt at the limit: video wins; the CPU keeps its forced priority for the next non-video cycle.
- cpu_req dropped before grant: starve_cnt is cleared the next edge; no access is issued.

## Test plan
- Reset then idle: all outputs 0, no rvalid for 10 cycles; assert reset with a read in flight, expect no rvalid after release.
- Video read 0x2A5 with RAM preloaded 0x37 at 0x2A5: ram_addr = 0x2A5 the next cycle, vid_rvalid = 1 with rdata = 0x37 two cycles after the request.
- ctl and cpu both requesting continuously, STARVE_LIMIT = 4: grant sequence is ctl ×4, cpu ×1, repeating; starve_cnt never exceeds 4.
- vid_req every 4th cycle, with ctl and cpu reads continuously requesting: video is never delayed; each rvalid strobe is tagged to the correct owner, with no rvalid overlap.
- CPU write 0x5A to 0x015, then a ctl read of 0x015 on the next cycle: ctl_rvalid returns rdata = 0x5A.
- ctl write during hold: ctl_req high while vid_req is high for 3 cycles; ctl_addr/wdata are held, ctl_gnt is asserted in cycle 4, and exactly one ram_we pulse follows.

Source files
------------

// File: rtl/tilemap_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tilemap_ram_arbiter
//
// Shares the single-port tilemap index RAM (1-cycle registered read latency)
// between three requesters and issues at most one access per cycle.
// The RAM port is registered. Read data is routed back to the requester that
// issued the read by a 2-stage owner tag pipeline.
//
// Priority: video > control engine > CPU. The exception is a CPU that has
// lost STARVE_LIMIT consecutive cycles to the control engine; it is then
// granted ahead of the control engine.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   vid_req/vid_addr           video read request (never stalled, no grant)
//   vid_rvalid                 video read data valid
//   ctl_req/we/addr/wdata      control engine request, held until ctl_gnt
//   ctl_gnt, ctl_rvalid        control grant (combinational), read valid
//   cpu_req/we/addr/wdata      CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid        CPU grant (combinational), read valid
//   rdata                      shared read data, qualified by *_rvalid
//   ram_addr/ram_we/ram_wdata  registered RAM access port
//   ram_rdata                  RAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module tilemap_ram_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_rvalid,
    input  logic                  ctl_req,
    input  logic                  ctl_we,
    input  logic [ADDR_WIDTH-1:0] ctl_addr,
    input  logic [DATA_WIDTH-1:0] ctl_wdata,
    output logic                  ctl_gnt,
    output logic                  ctl_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CTL  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    owner_e                tag1_q, tag1_d;   // owner of the access on the RAM port
    owner_e                tag2_q;           // owner of the data on ram_rdata
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic cpu_forced;
    logic ctl_win;
    logic cpu_win;

    // NOTE: every signal written here is assigned a default at the top, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cpu_forced = cpu_req && (starve_cnt_q == LIMIT);
        ctl_win    = !vid_req && ctl_req && !cpu_forced;
        cpu_win    = !vid_req && cpu_req && !ctl_win;

        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag1_d      = OWN_NONE;

        if (vid_req) begin
            ram_addr_d = vid_addr;
            tag1_d     = OWN_VID;
        end else if (ctl_win) begin
            ram_addr_d  = ctl_addr;
            ram_we_d    = ctl_we;
            ram_wdata_d = ctl_wdata;
            tag1_d      = ctl_we ? OWN_NONE : OWN_CTL;
        end else if (cpu_win) begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            tag1_d      = cpu_we ? OWN_NONE : OWN_CPU;
        end

        // Counts only cycles the CPU loses to the control engine; a video
        // slot leaves it untouched so forced priority survives into the
        // next non-video cycle.
        starve_cnt_d = starve_cnt_q;
        if (!cpu_req || cpu_win) begin
            starve_cnt_d = 4'd0;
        end else if (ctl_win && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            tag1_q       <= OWN_NONE;
            tag2_q       <= OWN_NONE;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag1_q;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Grants are suppressed during reset so no requester retires a transfer
    // that the cleared port registers would never issue.
    assign ctl_gnt    = ctl_win && !reset;
    assign cpu_gnt    = cpu_win && !reset;

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

    assign rdata      = ram_rdata;
    assign vid_rvalid = (tag2_q == OWN_VID);
    assign ctl_rvalid = (tag2_q == OWN_CTL);
    assign cpu_rvalid = (tag2_q == OWN_CPU);

endmodule

// File: tb/tb_tilemap_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tilemap_ram_arbiter
//
// Bench for tilemap_ram_arbiter. A behavioural RAM answers the DUT's RAM
// port. A reference model tracks the grant order, the memory contents in
// grant order and the expected read returns, and is compared against the
// DUT every cycle at the falling edge. Directed tests add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tilemap_ram_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_rvalid;
    logic          ctl_req, ctl_we;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_gnt, ctl_rvalid;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    tilemap_ram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rvalid(vid_rvalid),
        .ctl_req   (ctl_req),
        .ctl_we    (ctl_we),
        .ctl_addr  (ctl_addr),
        .ctl_wdata (ctl_wdata),
        .ctl_gnt   (ctl_gnt),
        .ctl_rvalid(ctl_rvalid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int a);
        return (a == 'h2A5) ? 8'h37 : 8'(a * 7 + 3);
    endfunction

    // Behavioural single-port RAM, one-cycle registered read.
    logic [DW-1:0] ram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = preload(i);
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        int            due;
        int            owner;   // 1 vid, 2 ctl, 3 cpu
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] m_mem [0:1023];
    int            m_starve;
    int            cyc;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wdata;

    initial begin
        int   winner;
        ret_t r;
        logic ev, ec, ep;
        for (int i = 0; i < 1024; i++) m_mem[i] = preload(i);
        cyc = 0; m_starve = 0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("rst_ram_addr", ram_addr, 0);
                check("rst_ram_we", ram_we, 0);
                check("rst_ram_wdata", ram_wdata, 0);
                check("rst_rvalid", {vid_rvalid, ctl_rvalid, cpu_rvalid}, 0);
                check("rst_gnt", {ctl_gnt, cpu_gnt}, 0);
                ret_q.delete();
                m_starve = 0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
            end else begin
                check("m_ram_addr", ram_addr, e_addr);
                check("m_ram_we", ram_we, e_we);
                if (e_we) check("m_ram_wdata", ram_wdata, e_wdata);

                ev = 1'b0; ec = 1'b0; ep = 1'b0;
                if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                    r = ret_q.pop_front();
                    ev = (r.owner == 1); ec = (r.owner == 2); ep = (r.owner == 3);
                    check("m_rdata", rdata, r.data);
                end
                check("m_rvalid", {vid_rvalid, ctl_rvalid, cpu_rvalid}, {ev, ec, ep});

                if (vid_req) winner = 1;
                else if (ctl_req && !(cpu_req && m_starve == LIM)) winner = 2;
                else if (cpu_req) winner = 3;
                else winner = 0;
                check("m_ctl_gnt", ctl_gnt, (winner == 2));
                check("m_cpu_gnt", cpu_gnt, (winner == 3));

                if (!cpu_req || winner == 3) m_starve = 0;
                else if (winner == 2 && m_starve < LIM) m_starve++;

                e_we = 1'b0;
                r.due = cyc + 2;
                r.owner = winner;
                case (winner)
                    1: begin
                        e_addr = vid_addr;
                        r.data = m_mem[vid_addr];
                        ret_q.push_back(r);
                    end
                    2: begin
                        e_addr = ctl_addr;
                        if (ctl_we) begin
                            e_we = 1'b1; e_wdata = ctl_wdata; m_mem[ctl_addr] = ctl_wdata;
                        end else begin
                            r.data = m_mem[ctl_addr];
                            ret_q.push_back(r);
                        end
                    end
                    3: begin
                        e_addr = cpu_addr;
                        if (cpu_we) begin
                            e_we = 1'b1; e_wdata = cpu_wdata; m_mem[cpu_addr] = cpu_wdata;
                        end else begin
                            r.data = m_mem[cpu_addr];
                            ret_q.push_back(r);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Move to just after the next rising edge, where inputs are changed.
    task automatic go();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int got [10];
        int exp_seq [10];
        int n_v, n_rv, n_ovl, n_gnt, we_cnt, inc_c, inc_p, rv_cnt;

        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        ctl_req = 1'b0; ctl_we = 1'b0; ctl_addr = '0; ctl_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) go();
        reset = 1'b0;

        // Idle after reset: no access, no rvalid.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rvalid", {vid_rvalid, ctl_rvalid, cpu_rvalid}, 0);
            check("idle_we", ram_we, 0);
            go();
        end

        // Video read of 0x2A5 (preloaded 0x37).
        vid_req = 1'b1; vid_addr = 10'h2A5;
        go();
        vid_req = 1'b0;
        @(negedge clk);
        check("vid_port_addr", ram_addr, 10'h2A5);
        check("vid_port_we", ram_we, 0);
        check("vid_rvalid_early", vid_rvalid, 0);
        go();
        @(negedge clk);
        check("vid_rvalid", vid_rvalid, 1);
        check("vid_rdata", rdata, 8'h37);
        repeat (3) go();

        // ctl vs cpu contention: ctl x4, cpu x1, repeating.
        exp_seq = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
        ctl_req = 1'b1; ctl_we = 1'b0; ctl_addr = 10'h100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got[i] = ctl_gnt ? 2 : (cpu_gnt ? 3 : 0);
            go();
            if (got[i] == 2) ctl_addr = ctl_addr + 10'd1;
            if (got[i] == 3) cpu_addr = cpu_addr + 10'd3;
        end
        ctl_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 10; i++) check($sformatf("starve_seq[%0d]", i), got[i], exp_seq[i]);
        repeat (4) go();

        // Video every 4th cycle against continuous ctl and cpu reads.
        n_v = 0; n_rv = 0; n_ovl = 0; n_gnt = 0; inc_c = 0; inc_p = 0;
        ctl_we = 1'b0; cpu_we = 1'b0; ctl_addr = 10'h300; cpu_addr = 10'h080;
        for (int i = 0; i < 28; i++) begin
            if (inc_c != 0) ctl_addr = ctl_addr + 10'd1;
            if (inc_p != 0) cpu_addr = cpu_addr + 10'd1;
            if (i < 24) begin
                vid_req = (i % 4 == 0); vid_addr = 10'(i * 5 + 1);
                ctl_req = 1'b1; cpu_req = 1'b1;
            end else begin
                vid_req = 1'b0; ctl_req = 1'b0; cpu_req = 1'b0;
            end
            @(negedge clk);
            inc_c = int'(ctl_gnt); inc_p = int'(cpu_gnt);
            n_gnt += int'(ctl_gnt) + int'(cpu_gnt);
            rv_cnt = int'(vid_rvalid) + int'(ctl_rvalid) + int'(cpu_rvalid);
            n_v += int'(vid_rvalid);
            n_rv += rv_cnt;
            if (rv_cnt > 1) n_ovl++;
            go();
        end
        check("mix_vid_rvalid_cnt", n_v, 6);
        check("mix_rvalid_total", n_rv, 24);
        check("mix_gnt_total", n_gnt, 18);
        check("mix_rvalid_overlap", n_ovl, 0);
        repeat (3) go();

        // CPU write 0x5A to 0x015, then ctl read of 0x015.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h015; cpu_wdata = 8'h5A;
        @(negedge clk);
        check("raw_cpu_gnt", cpu_gnt, 1);
        go();
        cpu_req = 1'b0; cpu_we = 1'b0;
        ctl_req = 1'b1; ctl_we = 1'b0; ctl_addr = 10'h015;
        @(negedge clk);
        check("raw_ctl_gnt", ctl_gnt, 1);
        go();
        ctl_req = 1'b0;
        @(negedge clk);
        check("raw_ctl_rvalid_early", ctl_rvalid, 0);
        go();
        @(negedge clk);
        check("raw_ctl_rvalid", ctl_rvalid, 1);
        check("raw_rdata", rdata, 8'h5A);
        repeat (3) go();

        // ctl write held behind three video cycles.
        vid_req = 1'b1; vid_addr = 10'h040;
        ctl_req = 1'b1; ctl_we = 1'b1; ctl_addr = 10'h133; ctl_wdata = 8'hC4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ctl_gnt_low", ctl_gnt, 0);
            go();
        end
        vid_req = 1'b0;
        @(negedge clk);
        check("hold_ctl_gnt", ctl_gnt, 1);
        go();
        ctl_req = 1'b0; ctl_we = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                check("hold_we_addr", ram_addr, 10'h133);
                check("hold_we_wdata", ram_wdata, 8'hC4);
            end
            go();
        end
        check("hold_we_pulses", we_cnt, 1);

        // Reset with a ctl read in flight: no rvalid afterwards.
        ctl_req = 1'b1; ctl_we = 1'b0; ctl_addr = 10'h2A5;
        @(negedge clk);
        check("rstf_ctl_gnt", ctl_gnt, 1);
        go();
        ctl_req = 1'b0;
        reset = 1'b1;
        repeat (2) go();
        reset = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rv_cnt += int'(vid_rvalid) + int'(ctl_rvalid) + int'(cpu_rvalid);
            go();
        end
        check("rstf_no_rvalid", rv_cnt, 0);

        repeat (2) go();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
